// File: rtl/gate_vector_sequencer.sv
// Drives all four {a,b} vectors into a 2-input gate, holds each for HOLD_CYCLES,
// and checks the gate output y against the TRUTH table, counting mismatches.
//   state | meaning
//   IDLE  | waiting for start, a=b=0
//   RUN   | applying vectors 00,01,10,11 for ROUNDS passes
//   DONE  | results held, a=b=0, pass valid
module gate_vector_sequencer #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [3:0]  TRUTH       = 4'b1000,
    parameter int unsigned ROUNDS      = 1,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       vec_idx
);

    localparam int unsigned HC_W = $clog2(HOLD_CYCLES);
    localparam int unsigned RC_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(ROUNDS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [1:0]       vec_q, vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             a_q, a_d;
    logic             b_q, b_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hc_q    <= '0;
            rc_q    <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            rc_q    <= rc_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        rc_d    = rc_q;
        vec_d   = vec_q;
        err_d   = err_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    hc_d    = '0;
                    rc_d    = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (hc_q == HC_LAST) begin
                    hc_d  = '0;
                    vec_d = vec_q + 2'd1;
                    if ((y != TRUTH[vec_q]) && (err_q != ERR_MAX)) begin
                        err_d = err_q + 1'b1;
                    end
                    if (vec_q == 2'd3) begin
                        // Final vector of the final round: pass must include this compare.
                        if (rc_q == RC_LAST) begin
                            state_d = ST_DONE;
                            pass_d  = (err_d == '0);
                        end else begin
                            rc_d = rc_q + 1'b1;
                        end
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        a_d = (state_d == ST_RUN) ? vec_d[1] : 1'b0;
        b_d = (state_d == ST_RUN) ? vec_d[0] : 1'b0;
    end

    assign a       = a_q;
    assign b       = b_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign vec_idx = vec_q;

endmodule
